// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: WIDTH-bit shift/rotate over log2(WIDTH) mux stages, a register slice every REG_STRIDE stages, valid/ready on both sides.
// Define BARREL_SHIFTER_FLAGS_EN to add the zero and carry outputs.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int REG_STRIDE = 1,
  localparam int SHW = $clog2(WIDTH),
  localparam int LAT = (SHW + REG_STRIDE - 1) / REG_STRIDE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BARREL_SHIFTER_FLAGS_EN
  output logic             zero,
  output logic             carry,
`endif
  output logic [WIDTH-1:0] c
);
  logic [WIDTH-1:0] st_x [SHW];
  logic [2:0]       st_m [SHW];
  logic [SHW-1:0]   st_b [SHW];
  logic [WIDTH-1:0] nx [SHW];
  logic [WIDTH-1:0] x_d [LAT];
  logic [2:0]       m_d [LAT];
  logic [SHW-1:0]   b_d [LAT];
  logic [WIDTH-1:0] x_q [LAT];
  logic [2:0]       m_q [LAT];
  logic [SHW-1:0]   b_q [LAT];
  logic [LAT-1:0]   v_q, vin;
  logic [LAT:0]     rdy;
  logic             rdy_en_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
  logic st_cy [SHW];
  logic ncy [SHW];
  logic cy_d [LAT];
  logic cy_q [LAT];
  logic zero_q;
  assign zero  = zero_q;
  assign carry = cy_q[LAT-1];
`endif
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int S = 1 << i;
    logic             en;
    logic [WIDTH-1:0] sra, y;
    if (i == 0) begin : g_src_in
      assign st_x[i] = a;
      assign st_m[i] = aluc;
      assign st_b[i] = b;
`ifdef BARREL_SHIFTER_FLAGS_EN
      assign st_cy[i] = 1'b0;
`endif
    end else if (i % REG_STRIDE == 0) begin : g_src_reg
      assign st_x[i] = x_q[i/REG_STRIDE-1];
      assign st_m[i] = m_q[i/REG_STRIDE-1];
      assign st_b[i] = b_q[i/REG_STRIDE-1];
`ifdef BARREL_SHIFTER_FLAGS_EN
      assign st_cy[i] = cy_q[i/REG_STRIDE-1];
`endif
    end else begin : g_src_comb
      assign st_x[i] = nx[i-1];
      assign st_m[i] = st_m[i-1];
      assign st_b[i] = st_b[i-1];
`ifdef BARREL_SHIFTER_FLAGS_EN
      assign st_cy[i] = ncy[i-1];
`endif
    end
    // pass-through modes (11x) never shift, whatever b holds
    assign en  = st_b[i][i] & (st_m[i][2:1] != 2'b11);
    assign sra = $signed(st_x[i]) >>> S;
    assign y   = (st_m[i] == 3'b000) ? sra :
                 (!st_m[i][2] && st_m[i][0]) ? st_x[i] << S :
                 (st_m[i] == 3'b010) ? st_x[i] >> S :
                 (st_m[i] == 3'b100) ? (st_x[i] << S) | (st_x[i] >> (WIDTH - S)) :
                 (st_x[i] >> S) | (st_x[i] << (WIDTH - S));
    assign nx[i] = en ? y : st_x[i];
`ifdef BARREL_SHIFTER_FLAGS_EN
    // the highest shifting stage sees the last bit to leave the word
    assign ncy[i] = !en ? st_cy[i] :
                    (!st_m[i][2] && !st_m[i][0]) ? st_x[i][S-1] :
                    !st_m[i][2] ? st_x[i][WIDTH-S] :
                    st_m[i][0] ? y[WIDTH-1] : y[0];
`endif
    if ((i + 1) % REG_STRIDE == 0 || i == SHW - 1) begin : g_slice
      assign x_d[i/REG_STRIDE] = nx[i];
      assign m_d[i/REG_STRIDE] = st_m[i];
      assign b_d[i/REG_STRIDE] = st_b[i];
`ifdef BARREL_SHIFTER_FLAGS_EN
      assign cy_d[i/REG_STRIDE] = ncy[i];
`endif
    end
  end
  always_comb begin
    rdy[LAT] = out_ready;
    for (int k = LAT - 1; k >= 0; k--) rdy[k] = !v_q[k] | rdy[k+1];
    for (int k = 0; k < LAT; k++) vin[k] = (k == 0) ? in_valid & rdy_en_q & rdy[0] : v_q[(k == 0) ? 0 : k - 1];
  end
  assign in_ready  = rdy_en_q & rdy[0];
  assign out_valid = v_q[LAT-1];
  assign c         = x_q[LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      v_q      <= '0;
      for (int k = 0; k < LAT; k++) begin
        x_q[k] <= '0;
        m_q[k] <= '0;
        b_q[k] <= '0;
`ifdef BARREL_SHIFTER_FLAGS_EN
        cy_q[k] <= 1'b0;
`endif
      end
`ifdef BARREL_SHIFTER_FLAGS_EN
      zero_q <= 1'b0;
`endif
    end else begin
      rdy_en_q <= 1'b1;
      for (int k = 0; k < LAT; k++) begin
        if (rdy[k]) begin
          v_q[k] <= vin[k];
          x_q[k] <= x_d[k];
          m_q[k] <= m_d[k];
          b_q[k] <= b_d[k];
`ifdef BARREL_SHIFTER_FLAGS_EN
          cy_q[k] <= cy_d[k];
`endif
        end
      end
`ifdef BARREL_SHIFTER_FLAGS_EN
      if (rdy[LAT-1]) zero_q <= (x_d[LAT-1] == '0);
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and randomized checks of pipelined_barrel_shifter (WIDTH=32, REG_STRIDE=1)
// against a queue-based reference model; define BARREL_SHIFTER_FLAGS_EN to also check zero/carry.
module tb_pipelined_barrel_shifter;
  localparam int W = 32, LAT = 5;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = '0;
  logic [4:0] b = '0;
  logic [2:0] aluc = '0;
  logic in_ready, out_valid;
  logic [W-1:0] c;
`ifdef BARREL_SHIFTER_FLAGS_EN
  logic zero, carry;
`endif
  typedef struct { logic [W-1:0] c; logic cy; int t; } item_t;
  item_t q[$];
  int cyc = 0, n_vec = 0, n_err = 0;
  bit acc;

  pipelined_barrel_shifter #(.WIDTH(W), .REG_STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BARREL_SHIFTER_FLAGS_EN
    .zero(zero), .carry(carry),
`endif
    .c(c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_c(logic [W-1:0] x, logic [4:0] s, logic [2:0] m);
    logic [2*W-1:0] d, l;
    d = {x, x};
    case (m)
      3'd0: return $signed(x) >>> s;
      3'd1, 3'd3: return x << s;
      3'd2: return x >> s;
      3'd4: begin l = d << s; return l[2*W-1:W]; end
      3'd5: begin l = d >> s; return l[W-1:0]; end
      default: return x;
    endcase
  endfunction

  function automatic logic ref_carry(logic [W-1:0] x, logic [4:0] s, logic [2:0] m);
    logic [W-1:0] r;
    r = ref_c(x, s, m);
    if (s == 0 || m >= 3'd6) return 1'b0;
    case (m)
      3'd1, 3'd3: return x[W-s];
      3'd0, 3'd2: return x[s-1];
      3'd4: return r[0];
      default: return r[W-1];
    endcase
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    #1;
    acc = in_valid && in_ready;
    chk("in_ready", in_ready, !(q.size() == LAT && !out_ready));
    chk("out_valid", out_valid, q.size() > 0 && cyc - q[0].t >= LAT);
    if (out_valid && q.size() > 0) begin
      chk("c", c, q[0].c);
`ifdef BARREL_SHIFTER_FLAGS_EN
      chk("carry", carry, q[0].cy);
      chk("zero", zero, q[0].c == '0);
`endif
      if (out_ready) void'(q.pop_front());
    end
    if (acc) q.push_back('{ref_c(a, b, aluc), ref_carry(a, b, aluc), cyc});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic op(logic [W-1:0] x, logic [4:0] s, logic [2:0] m);
    int n = 0;
    in_valid = 1; a = x; b = s; aluc = m;
    do begin cycle(); n++; end while (!acc && n < 50);
    chk("accept", acc, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (LAT + 2) cycle();
    chk("drained", q.size(), 0);
  endtask

  task automatic run_one(logic [W-1:0] x, logic [4:0] s, logic [2:0] m, logic [W-1:0] exp);
    int lat = 1;
    drain();
    op(x, s, m);
    while (!out_valid && lat < 20) begin cycle(); lat++; end
    chk("latency", lat, LAT);
    chk("result", c, exp);
  endtask

  initial begin
    logic [W-1:0] got[$];
    int got_j[$];
    int sent;
    logic [W-1:0] x;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", in_ready, 1);

    run_one(32'h8000_0000, 5'd4, 3'b000, 32'hF800_0000);
    run_one(32'h0000_0001, 5'd1, 3'b101, 32'h8000_0000);
    run_one(32'h8000_0001, 5'd4, 3'b100, 32'h0000_0018);
    for (int m = 0; m < 8; m++) begin
      x = $urandom;
      run_one(x, 5'd0, 3'(m), x);
    end
    run_one(32'h1234_5678, 5'd9, 3'b110, 32'h1234_5678);
    run_one(32'hFFFF_FFFF, 5'd31, 3'b010, 32'h0000_0001);
`ifdef BARREL_SHIFTER_FLAGS_EN
    run_one(32'h8000_0001, 5'd1, 3'b001, 32'h0000_0002);
    chk("flag_sll_carry", carry, 1);
    chk("flag_sll_zero", zero, 0);
    run_one(32'h0000_0001, 5'd1, 3'b010, 32'h0000_0000);
    chk("flag_srl_carry", carry, 1);
    chk("flag_srl_zero", zero, 1);
`endif

    drain();
    sent = 0;
    a = 1; aluc = 3'b001;
    for (int j = 0; j < 30; j++) begin
      out_ready = !(j >= 3 && j <= 9);
      in_valid = sent < 8;
      b = 5'(sent);
      #1;
      if (out_valid && out_ready) begin got.push_back(c); got_j.push_back(j); end
      if (j == 9) chk("bp_full_in_ready", in_ready, 0);
      cycle();
      if (acc) sent++;
    end
    in_valid = 0;
    chk("bp_sent", sent, 8);
    chk("bp_count", got.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("bp_order", got[k], 32'(1) << k);
      chk("bp_gapless", got_j[k], got_j[0] + k);
    end

    for (int j = 0; j < 400; j++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a = $urandom;
      b = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      aluc = 3'($urandom);
      cycle();
    end
    drain();

    out_ready = 0;
    op(32'h0000_00F1, 5'd3, 3'b100);
    op(32'h0000_00F2, 5'd5, 3'b100);
    op(32'h0000_00F3, 5'd7, 3'b100);
    repeat (LAT) cycle();
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_c", c, 0);
    chk("async_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    q.delete();
    #1 chk("rel_in_ready", in_ready, 0);
    @(posedge clk);
    cyc++;
    #1;
    out_ready = 1;
    repeat (LAT + 2) cycle();
    run_one(32'h0000_0003, 5'd2, 3'b011, 32'h0000_000C);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
